// File: rtl/tug_playfield.sv
// Tug-of-war playfield: conditions L/R/next buttons, moves one lit LED along
// a 9-LED bar, latches round winners and drives per-player score displays.
module tug_playfield #(
    parameter int WIN_SCORE = 7,
    parameter int CENTER    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       next,
    output logic [9:1] led,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic       game_over
);

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        WIN_ONE = 2'd1,
        WIN_TWO = 2'd2
    } state_t;

    localparam logic [3:0] POS_CENTER = 4'(CENTER);
    localparam logic [9:1] LED_CENTER = 9'(1) << (CENTER - 1);
    localparam logic [2:0] SCORE_MAX  = 3'(WIN_SCORE);

    // Button order in the conditioning vectors: {next, L, R}
    logic [2:0] btn;
    logic [2:0] s1_q;
    logic [2:0] s2_q;
    logic [2:0] h_q;
    logic [2:0] press;
    logic       press_r;
    logic       press_l;
    logic       press_n;

    state_t     state_q;
    logic [3:0] pos_q;
    logic [9:1] led_q;
    logic [2:0] score1_q;
    logic [2:0] score2_q;
    logic       game_over_q;
    logic [2:0] score1_d;
    logic [2:0] score2_d;

    assign btn     = {next, L, R};
    assign press   = s2_q & ~h_q;
    assign press_r = press[0];
    assign press_l = press[1];
    assign press_n = press[2];

    assign score1_d = score1_q + 3'd1;
    assign score2_d = score2_q + 3'd1;

    // Two-flop synchronizer plus history flop; preset to 1 so a button
    // held through reset must be released before it can press again
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 3'b111;
            s2_q <= 3'b111;
            h_q  <= 3'b111;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
            h_q  <= s2_q;
        end
    end

    // Round FSM: moves the light, detects push-off, keeps score
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLAY;
            pos_q       <= POS_CENTER;
            led_q       <= LED_CENTER;
            score1_q    <= 3'd0;
            score2_q    <= 3'd0;
            game_over_q <= 1'b0;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (press_r && !press_l) begin
                        if (pos_q == 4'd1) begin
                            state_q     <= WIN_ONE;
                            led_q       <= '0;
                            score1_q    <= score1_d;
                            game_over_q <= (score1_d == SCORE_MAX);
                        end else begin
                            pos_q <= pos_q - 4'd1;
                            led_q <= led_q >> 1;
                        end
                    end else if (press_l && !press_r) begin
                        if (pos_q == 4'd9) begin
                            state_q     <= WIN_TWO;
                            led_q       <= '0;
                            score2_q    <= score2_d;
                            game_over_q <= (score2_d == SCORE_MAX);
                        end else begin
                            pos_q <= pos_q + 4'd1;
                            led_q <= led_q << 1;
                        end
                    end
                end
                WIN_ONE, WIN_TWO: begin
                    if (press_n && !game_over_q) begin
                        state_q <= PLAY;
                        pos_q   <= POS_CENTER;
                        led_q   <= LED_CENTER;
                    end
                end
                default: begin
                    state_q <= PLAY;
                    pos_q   <= POS_CENTER;
                    led_q   <= LED_CENTER;
                end
            endcase
        end
    end

    // Active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [2:0] v);
        logic [6:0] s;
        s = 7'b1000000;
        unique case (v)
            3'd0: s = 7'b1000000;
            3'd1: s = 7'b1111001;
            3'd2: s = 7'b0100100;
            3'd3: s = 7'b0110000;
            3'd4: s = 7'b0011001;
            3'd5: s = 7'b0010010;
            3'd6: s = 7'b0000010;
            3'd7: s = 7'b1111000;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // Score displays decoded straight from the score registers
    always_comb begin
        hex1 = seg7(score1_q);
        hex2 = seg7(score2_q);
    end

    assign led       = led_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_tug_playfield.sv
// Self-checking bench for tug_playfield: directed scenarios plus random
// button traffic checked against a press-event level game model.
module tb_tug_playfield;

    localparam int WIN = 7;
    localparam int CTR = 5;

    logic       clk;
    logic       reset;
    logic       L;
    logic       R;
    logic       nx;
    logic [9:1] led;
    logic [2:0] score1;
    logic [2:0] score2;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic       game_over;

    int n_chk;
    int n_fail;

    tug_playfield #(.WIN_SCORE(WIN), .CENTER(CTR)) dut (
        .clk      (clk),
        .reset    (reset),
        .L        (L),
        .R        (R),
        .next     (nx),
        .led      (led),
        .score1   (score1),
        .score2   (score2),
        .hex1     (hex1),
        .hex2     (hex2),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Game state: 0 = playing, 1 = player one won round, 2 = player two won
    int m_pos;
    int m_st;
    int m_s1;
    int m_s2;
    bit m_go;
    bit prev_l, prev_r, prev_n;
    bit [2:0] ev_new;
    bit [2:0] ev_old;

    logic [6:0] seg_tab [0:7];
    initial begin
        seg_tab[0] = 7'b1000000;
        seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001;
        seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010;
        seg_tab[7] = 7'b1111000;
    end

    function automatic logic [9:1] exp_led();
        logic [9:1] v;
        v = '0;
        if (m_st == 0) v[m_pos] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_pos  = CTR;
        m_st   = 0;
        m_s1   = 0;
        m_s2   = 0;
        m_go   = 0;
        prev_l = 1;
        prev_r = 1;
        prev_n = 1;
        ev_new = '0;
        ev_old = '0;
    endtask

    // A rising sample is seen as a press that acts two edges later
    task automatic model_edge(input bit l, input bit r, input bit n);
        bit [2:0] ev;
        ev     = ev_old;
        ev_old = ev_new;
        ev_new = {n & ~prev_n, l & ~prev_l, r & ~prev_r};
        prev_l = l;
        prev_r = r;
        prev_n = n;
        if (m_st == 0) begin
            if (ev[0] && !ev[1]) begin
                if (m_pos == 1) begin
                    m_st = 1;
                    m_s1++;
                    m_go = (m_s1 == WIN);
                end else m_pos--;
            end else if (ev[1] && !ev[0]) begin
                if (m_pos == 9) begin
                    m_st = 2;
                    m_s2++;
                    m_go = (m_s2 == WIN);
                end else m_pos++;
            end
        end else if (ev[2] && !m_go) begin
            m_st  = 0;
            m_pos = CTR;
        end
    endtask

    task automatic step(input bit l, input bit r, input bit n);
        L  = l;
        R  = r;
        nx = n;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(l, r, n);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0);
    endtask

    // One press: held 3 cycles then released 3 cycles
    task automatic pulse(input bit l, input bit r, input bit n);
        for (int i = 0; i < 3; i++) step(l, r, n);
        idle(3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        idle(10);
        n_chk++;
        if (led !== 9'b000010000) begin
            n_fail++;
            $display("FAIL reset_led got %b want %b", led, 9'b000010000);
        end
        n_chk++;
        if (score1 !== 3'd0 || score2 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_scores got %0d/%0d want 0/0", score1, score2);
        end
        n_chk++;
        if (hex1 !== 7'b1000000 || hex2 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_hex got %b/%b want 1000000", hex1, hex2);
        end
        n_chk++;
        if (game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_go got %b want 0", game_over);
        end
    endtask

    task automatic test_r_steps();
        logic [9:1] want;
        // latency on the first pulse: unchanged after N, N+1; moved at N+2
        step(0, 1, 0);
        step(0, 1, 0);
        n_chk++;
        if (led !== 9'b000010000) begin
            n_fail++;
            $display("FAIL latency_early got %b want %b", led, 9'b000010000);
        end
        step(0, 1, 0);
        n_chk++;
        if (led !== 9'b000001000) begin
            n_fail++;
            $display("FAIL latency_step got %b want %b", led, 9'b000001000);
        end
        idle(3);
        for (int k = 2; k <= 4; k++) begin
            pulse(0, 1, 0);
            want = '0;
            want[5 - k] = 1'b1;
            n_chk++;
            if (led !== want) begin
                n_fail++;
                $display("FAIL r_step%0d got %b want %b", k, led, want);
            end
        end
        pulse(0, 1, 0);
        n_chk++;
        if (led !== '0 || score1 !== 3'd1 || hex1 !== 7'b1111001) begin
            n_fail++;
            $display("FAIL win_one got led=%b s1=%0d hex1=%b want 0/1/1111001",
                     led, score1, hex1);
        end
        pulse(0, 0, 1);
        n_chk++;
        if (led !== 9'b000010000) begin
            n_fail++;
            $display("FAIL next_round got %b want %b", led, 9'b000010000);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        idle(3);
        n_chk++;
        if (led !== 9'b000100000) begin
            n_fail++;
            $display("FAIL hold_l got %b want %b", led, 9'b000100000);
        end
        pulse(1, 1, 0);
        n_chk++;
        if (led !== 9'b000100000) begin
            n_fail++;
            $display("FAIL both got %b want %b", led, 9'b000100000);
        end
    endtask

    task automatic test_win_two();
        for (int i = 0; i < 3; i++) pulse(1, 0, 0);
        n_chk++;
        if (led !== 9'b100000000) begin
            n_fail++;
            $display("FAIL pos9 got %b want %b", led, 9'b100000000);
        end
        pulse(1, 0, 0);
        n_chk++;
        if (led !== '0 || score2 !== 3'd1 || hex2 !== 7'b1111001) begin
            n_fail++;
            $display("FAIL win_two got led=%b s2=%0d hex2=%b want 0/1/1111001",
                     led, score2, hex2);
        end
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        n_chk++;
        if (led !== '0 || score1 !== 3'd1 || score2 !== 3'd1) begin
            n_fail++;
            $display("FAIL win_ignore got led=%b s=%0d/%0d want 0 1/1",
                     led, score1, score2);
        end
        pulse(0, 0, 1);
        n_chk++;
        if (led !== 9'b000010000) begin
            n_fail++;
            $display("FAIL win_two_next got %b want %b", led, 9'b000010000);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        idle(2);
        for (int w = 1; w <= 7; w++) begin
            for (int i = 0; i < 4; i++) pulse(0, 1, 0);
            step(0, 1, 0);
            step(0, 1, 0);
            if (w == 7) begin
                n_chk++;
                if (game_over !== 1'b0) begin
                    n_fail++;
                    $display("FAIL go_early got %b want 0", game_over);
                end
            end
            step(0, 1, 0);
            n_chk++;
            if (score1 !== 3'(w) || game_over !== (w == 7)) begin
                n_fail++;
                $display("FAIL win%0d got s1=%0d go=%b want %0d/%b",
                         w, score1, game_over, w, (w == 7));
            end
            idle(3);
            if (w < 7) pulse(0, 0, 1);
        end
        n_chk++;
        if (hex1 !== 7'b1111000) begin
            n_fail++;
            $display("FAIL hex7 got %b want 1111000", hex1);
        end
        pulse(0, 0, 1);
        n_chk++;
        if (led !== '0 || game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL over_dark got led=%b go=%b want 0/1", led, game_over);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        idle(2);
        for (int i = 0; i < 5; i++) pulse(0, 1, 0);
        n_chk++;
        if (led !== '0 || score1 !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_reset got led=%b s1=%0d want 0/1", led, score1);
        end
        R = 1'b1;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_chk++;
        if (led !== 9'b000010000 || score1 !== 3'd0 || score2 !== 3'd0 ||
            game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got led=%b s=%0d/%0d go=%b",
                     led, score1, score2, game_over);
        end
        step(0, 1, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        n_chk++;
        if (led !== 9'b000010000) begin
            n_fail++;
            $display("FAIL held_through got %b want %b", led, 9'b000010000);
        end
        idle(3);
        pulse(0, 1, 0);
        n_chk++;
        if (led !== 9'b000001000) begin
            n_fail++;
            $display("FAIL repress got %b want %b", led, 9'b000001000);
        end
    endtask

    task automatic test_random();
        bit l, r, n;
        int bad;
        do_reset();
        l = 0;
        r = 0;
        n = 0;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) l = ~l;
            if ($urandom_range(0, 3) == 0) r = ~r;
            if ($urandom_range(0, 7) == 0) n = ~n;
            if (m_go && $urandom_range(0, 30) == 0) do_reset();
            step(l, r, n);
            n_chk++;
            if (led !== exp_led() || score1 !== 3'(m_s1) ||
                score2 !== 3'(m_s2) || game_over !== m_go ||
                hex1 !== seg_tab[m_s1] || hex2 !== seg_tab[m_s2]) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random c=%0d got led=%b s=%0d/%0d go=%b hex=%b/%b want led=%b s=%0d/%0d go=%b",
                             c, led, score1, score2, game_over, hex1, hex2,
                             exp_led(), m_s1, m_s2, m_go);
                bad++;
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        L      = 1'b0;
        R      = 1'b0;
        nx     = 1'b0;
        model_reset();
        test_reset();
        test_r_steps();
        test_hold();
        test_win_two();
        test_game_over();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tug_playfield.md
Name: tug_playfield

Overview:
- Playfield engine for the tug-of-war game. It takes raw L/R player buttons and moves a single lit LED along a 9-LED bar (led[9:1]).
- It detects push-off at either end, latches the round winner and keeps a per-player score with 7-segment outputs.
- It is the producer side of the led9/led1/L/R interface: led[9] and led[1] feed the end-of-bar win logic downstream.

Parameters:
- WIN_SCORE, 7, score at which the match ends (1..7).
- CENTER, 5, LED index lit at reset and at each round start (2..8).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- L  input  1  raw left-player button, active-high, asynchronous to clk
- R  input  1  raw right-player button, active-high, asynchronous to clk
- next  input  1  raw "next round" button, active-high, asynchronous
- led  output  9  led[9:1], one-hot light position; all zero when no round is in play
- score1  output  3  player-one round wins
- score2  output  3  player-two round wins
- hex1  output  7  7-seg of score1, active-low, segment order {g,f,e,d,c,b,a}
- hex2  output  7  7-seg of score2, same encoding
- game_over  output  1  high once either score reaches WIN_SCORE

Behaviour:
- Reset is asynchronous and active-high on all flops. Reset values:
  - pos = CENTER, led = one-hot(CENTER), state PLAY.
  - score1 = score2 = 0, hex1 = hex2 = 1000000, game_over = 0.
  - All synchronizer and history flops = 1, so a button held through reset produces no press until it is released and pressed again.
- Input conditioning, per button (L, R, next): 2-flop synchronizer s1 -> s2, then history flop h <= s2.
  - press = s2 & ~h, a one-cycle pulse.
  - Latency: input first sampled at edge N -> press valid between N+1 and N+2 -> state/led update at edge N+2.
  - A held button yields exactly one press.
- PLAY state:
  - Lone R press, pos > 1: pos <= pos-1. Lone R press, pos == 1: go to WIN_ONE.
  - Lone L press, pos < 9: pos <= pos+1. Lone L press, pos == 9: go to WIN_TWO.
  - L and R press in the same cycle: no move. Neither pressed: hold.
  - next presses are ignored in PLAY.
- On entry to WIN_ONE: score1 increments once, on the transition cycle only. On entry to WIN_TWO: score2 increments once.
  - Scores never exceed WIN_SCORE; an increment at WIN_SCORE is impossible because game_over blocks further rounds.
- WIN_ONE / WIN_TWO:
  - led = 0. L/R presses are ignored.
  - A next press with game_over == 0 sets pos <= CENTER and returns to PLAY on the same edge.
  - A next press with game_over == 1 is ignored. The match ends here and only reset restarts it.
- game_over is registered: it rises on the same edge the winning score reaches WIN_SCORE.
- hex encoding (0..7):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - hexN is combinational from scoreN.
- Reset mid-round or mid-win state: everything returns to reset values immediately, with no clock needed.
- led is registered; exactly one bit is set in PLAY and zero bits are set in the WIN states.

Test Plan:
- Reset then idle 10 cycles -> led = 9'b000010000, scores 0, hex1 = hex2 = 1000000, game_over = 0.
- Four separate R pulses (each held 3 cycles, 3 cycles apart) -> led steps 5->4->3->2->1; each step lands 2 edges after first sampling. A fifth R press -> led = 0, score1 = 1, hex1 = 1111001.
- Hold L for 20 cycles from pos 5 -> exactly one move to pos 6. Raise L and R on the same cycle -> led unchanged.
- From pos 9, L press -> WIN_TWO, score2 = 1, hex2 = 1111001. Further L/R presses -> no change. next press -> led = 000010000, PLAY.
- With WIN_SCORE = 7, run 7 player-one wins -> score1 = 7, hex1 = 1111000, game_over = 1 on the 7th win edge. next press -> stays dark.
- Assert reset asynchronously mid-WIN_ONE between clock edges -> led = one-hot(5), scores 0 and game_over 0 before the next edge. Hold R through reset release -> no movement until R is released and re-pressed.
